rtc_serial_master: RTL

// - Serial bus master driving the uPD4990 RTC pins (CS, CLK, DATA_IN, STROBE) and capturing its DATA_OUT.
// - Sits directly upstream of the RTC: the system I/O register side hands it a command, plus a 48-bit time
//   for writes; the block runs the bit sequence and returns the 48-bit time for reads.
// - Replaces CPU bit-banging during simulation. Gives the RTC model a deterministic, cycle-exact stimulus source.

---
 rtl/rtc_pkg.sv | 25 ++
 rtl/rtc_phase_timer.sv | 26 ++
 rtl/rtc_serial_master.sv | 118 +++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the uPD4990 serial master: operation codes, RTC
// command nibbles and the sequencer state encoding.
package rtc_pkg;

    localparam logic [1:0] OP_CMD   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam logic [3:0] CMD_SHIFT = 4'h1;
    localparam logic [3:0] CMD_TSET  = 4'h2;
    localparam logic [3:0] CMD_TREAD = 4'h3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SH_LO  = 4'd1,
        ST_SH_HI  = 4'd2,
        ST_STB_SU = 4'd3,
        ST_STB_HI = 4'd4,
        ST_STB_HD = 4'd5,
        ST_RD_LO  = 4'd6,
        ST_RD_HI  = 4'd7,
        ST_FIN    = 4'd8
    } state_t;

endpackage

// File: rtl/rtc_phase_timer.sv
// Phase down-counter: reloaded with DIV-1 on every state change, tc marks
// the last system cycle of the current phase.
module rtc_phase_timer #(
    parameter int DIV = 12
) (
    input  logic clk,
    input  logic srst,
    input  logic load,
    output logic tc
);

    logic [7:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= 8'(DIV - 1);
        end else if (cnt_reg != 8'd0) begin
            cnt_reg <= cnt_reg - 8'd1;
        end
    end

    assign tc = (cnt_reg == 8'd0);

endmodule

// File: rtl/rtc_serial_master.sv
// Serial bus master for the uPD4990 RTC: shifts a command (and optionally a
// 48-bit time) out LSB first, strobes it, and optionally reads the time back.
module rtc_serial_master
    import rtc_pkg::*;
#(
    parameter int DIV       = 12,
    parameter int DATA_BITS = 48,
    parameter int CMD_BITS  = 4
) (
    input  logic                 CLK_24M,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [1:0]           OP,
    input  logic [CMD_BITS-1:0]  CMD,
    input  logic [DATA_BITS-1:0] WR_TIME,
    output logic [DATA_BITS-1:0] RD_TIME,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 RTC_CS,
    output logic                 RTC_CLK,
    output logic                 RTC_DIN,
    output logic                 RTC_STB,
    input  logic                 RTC_DOUT
);

    localparam int TX_BITS = DATA_BITS + CMD_BITS;

    state_t               state_reg, state_next;
    logic [1:0]           op_reg;
    logic [TX_BITS-1:0]   tx_reg, tx_init;
    logic [DATA_BITS-1:0] rx_reg, rd_time_reg;
    logic [5:0]           bit_cnt_reg;
    logic                 din_reg;
    logic                 accept, tc, phase_load, last_bit;

    assign accept     = START && (state_reg == ST_IDLE);
    assign last_bit   = (bit_cnt_reg == 6'd1);
    assign phase_load = (state_next != state_reg);

    rtc_phase_timer #(.DIV(DIV)) u_timer (
        .clk  (CLK_24M),
        .srst (RESET),
        .load (phase_load),
        .tc   (tc)
    );

    // Short ops place their nibble in the low bits so it goes out first.
    always_comb begin
        tx_init = TX_BITS'(CMD);
        if (OP == OP_WRITE) begin
            tx_init = {CMD_BITS'(CMD_TSET), WR_TIME};
        end else if (OP == OP_READ) begin
            tx_init = TX_BITS'(CMD_TREAD);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_SH_LO;
            ST_SH_LO:  if (tc) state_next = ST_SH_HI;
            ST_SH_HI:  if (tc) state_next = last_bit ? ST_STB_SU : ST_SH_LO;
            ST_STB_SU: if (tc) state_next = ST_STB_HI;
            ST_STB_HI: if (tc) state_next = ST_STB_HD;
            ST_STB_HD: if (tc) state_next = (op_reg == OP_READ) ? ST_RD_LO : ST_FIN;
            ST_RD_LO:  if (tc) state_next = ST_RD_HI;
            ST_RD_HI:  if (tc) state_next = last_bit ? ST_FIN : ST_RD_LO;
            ST_FIN:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            op_reg      <= OP_CMD;
            tx_reg      <= '0;
            rx_reg      <= '0;
            rd_time_reg <= '0;
            bit_cnt_reg <= '0;
            din_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg      <= OP;
                din_reg     <= tx_init[0];
                tx_reg      <= tx_init >> 1;
                bit_cnt_reg <= (OP == OP_WRITE) ? 6'(TX_BITS) : 6'(CMD_BITS);
            end else if (state_reg == ST_SH_HI && tc) begin
                bit_cnt_reg <= bit_cnt_reg - 6'd1;
                if (state_next == ST_SH_LO) begin
                    din_reg <= tx_reg[0];
                    tx_reg  <= tx_reg >> 1;
                end
            end else if (state_reg == ST_RD_HI && tc) begin
                bit_cnt_reg <= bit_cnt_reg - 6'd1;
            end else if (state_reg == ST_STB_HD && state_next == ST_RD_LO) begin
                bit_cnt_reg <= 6'(DATA_BITS);
            end
            // DOUT is sampled in the last low cycle, just before the rising edge.
            if (state_reg == ST_RD_LO && tc) begin
                rx_reg <= {RTC_DOUT, rx_reg[DATA_BITS-1:1]};
            end
            if (state_next == ST_FIN && op_reg == OP_READ) begin
                rd_time_reg <= rx_reg;
            end
        end
    end

    assign RD_TIME = rd_time_reg;
    assign BUSY    = (state_reg != ST_IDLE);
    assign DONE    = (state_reg == ST_FIN);
    assign RTC_CS  = BUSY;
    assign RTC_CLK = (state_reg == ST_SH_HI) || (state_reg == ST_RD_HI);
    assign RTC_STB = (state_reg == ST_STB_HI);
    assign RTC_DIN = din_reg && ((state_reg == ST_SH_LO) || (state_reg == ST_SH_HI));

endmodule
